sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//   Shares the single SDRAM controller port between NUM_REQ masters (dcache, icache, blitter/aux DMA).
//   Round-robin grant per transaction. Records the owner of every outstanding read in issue order and
//   steers returning read beats back to that owner. Sits between the CPU-side caches and the SDRAM controller.
// PARAMETERS
//   NUM_REQ    3   number of requesting masters (>=2); index 0 = dcache
//   OWN_DEPTH  4   max outstanding reads (owner FIFO depth, power of 2)
//   ADDR_W     26  SDRAM word-address width
// PORTS
//   clock            in   1              system clock
//   reset            in   1              asynchronous, active-high reset
//   m_request        in   NUM_REQ        master i is presenting a request
//   m_ready          out  NUM_REQ        master i's request is accepted this cycle
//   m_addr           in   NUM_REQ*ADDR_W request address per master
//   m_write          in   NUM_REQ        1=write, 0=read
//   m_burst          in   NUM_REQ        1=16-beat burst read, 0=single
//   m_wstrb          in   NUM_REQ*4      byte enables for writes
//   m_wdata          in   NUM_REQ*32     write data; tag for reads
//   m_rvalid         out  NUM_REQ        read beat for master i
//   m_rdata          out  32             read data (shared to all masters)
//   m_raddress       out  ADDR_W         address of current read beat (shared)
//   m_complete       out  1              final beat of transaction (shared)
//   sdram_ready      in   1              controller can accept a request
//   sdram_request    out  1              request to controller
//   sdram_addr/_write/_burst/_wstrb/_wdata  out  ADDR_W/1/1/4/32  muxed from granted master
//   sdram_rvalid/_rdata/_raddress/_complete in   1/32/ADDR_W/1   read return from controller
//   protocol_error   out  1              sticky: read beat returned with owner FIFO empty
// BEHAVIOUR
//   - Reset: rr_ptr=0, owner FIFO empty, protocol_error=0; all outputs 0 during and after reset until requests appear.
//   - Eligibility: master i eligible if m_request[i] && (m_write[i] || !fifo_full).
//   - Grant: combinational; first eligible master scanning from rr_ptr upward, wrapping at NUM_REQ.
//   - sdram_request = any eligible; sdram_* payload = granted master's fields; zeros when none eligible.
//   - Accept: m_ready[g] = sdram_request && sdram_ready; all other m_ready = 0. Zero-cycle latency.
//   - On accept: rr_ptr <= (g+1) mod NUM_REQ; if read, push g into owner FIFO.
//   - No accept: rr_ptr holds; grant may change if requests change (masters hold until m_ready).
//   - Return: m_rvalid[head] = sdram_rvalid when FIFO non-empty; m_rdata/m_raddress/m_complete pass through
//     combinationally from sdram_*. Pop on sdram_rvalid && sdram_complete (singles return complete=1).
//   - Reads from one master to the controller return in issue order; FIFO order = return order.
//   - Full FIFO: reads stall (not eligible); writes still granted. Push and pop same cycle when full: pop
//     first, read granted only if fifo_full was 0 at start of cycle (no bypass) -> no overflow.
//   - Empty FIFO + sdram_rvalid: beat dropped, no m_rvalid, protocol_error <= 1 (cleared only by reset).
//   - Simultaneous push and pop with count unchanged is legal at any occupancy below full.
//   - Reset mid-burst: FIFO flushed; controller is reset by the same signal, so no stale beats expected.
// STRUCTURE
//   - Package sdram_arb_pkg: typedef req_id_t = logic[$clog2(NUM_REQ)-1:0]; struct sdram_req_t
//     {addr, write, burst, wstrb, wdata}; localparam BURST_LEN = 16.
//   - Sub-module sdram_arb_owner_fifo: OWN_DEPTH x req_id_t, push/pop/full/empty/head, ptr wrap via
//     extra pointer bit. Grant logic and rr_ptr stay in the top module.
// TESTING
//   1. Masters 0,1,2 request reads continuously, sdram_ready=1 -> grants 0,1,2,0,1,2; m_ready one-hot per cycle.
//   2. Master 1 burst read at addr 0x100, master 0 single read 0x200; controller returns 16 beats then 1
//      -> m_rvalid[1] for 16 beats (complete on 16th), then m_rvalid[0] one beat, FIFO empty after.
//   3. Issue 4 reads with no return (FIFO full); master 2 write pending -> write granted, further reads
//      held with m_ready=0 until first complete beat pops the FIFO.
//   4. sdram_ready=0 for 5 cycles with master 0 requesting -> sdram_request=1 held, payload stable,
//      rr_ptr unchanged; accepted on first cycle ready=1.
//   5. sdram_rvalid=1, complete=1 with empty FIFO -> no m_rvalid, protocol_error=1 and stays 1.
//   6. Assert reset asynchronously mid-burst (FIFO count 2) -> outputs 0 immediately, FIFO empty,
//      rr_ptr=0; after release master 0 wins first.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Defaults describe the standard build: dcache, icache and blitter/aux DMA
// sharing one controller port with up to four reads in flight.
package sdram_arb_pkg;

    localparam int DEF_NUM_REQ   = 3;
    localparam int DEF_OWN_DEPTH = 4;
    localparam int DEF_ADDR_W    = 26;
    localparam int BURST_LEN     = 16;

    // Identifies one requesting master (index 0 is the dcache)
    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

    // One request as presented to the SDRAM controller
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  write;
        logic                  burst;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
    } sdram_req_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the SDRAM
// controller. The arbiter uses the slave view; the surrounding system
// (masters plus controller) uses the master view.
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W
);

    // master request side
    logic [NUM_REQ-1:0]        m_request;
    logic [NUM_REQ-1:0]        m_ready;
    logic [NUM_REQ*ADDR_W-1:0] m_addr;
    logic [NUM_REQ-1:0]        m_write;
    logic [NUM_REQ-1:0]        m_burst;
    logic [NUM_REQ*4-1:0]      m_wstrb;
    logic [NUM_REQ*32-1:0]     m_wdata;

    // master read-return side
    logic [NUM_REQ-1:0]        m_rvalid;
    logic [31:0]               m_rdata;
    logic [ADDR_W-1:0]         m_raddress;
    logic                      m_complete;

    // controller request side
    logic                      sdram_ready;
    logic                      sdram_request;
    logic [ADDR_W-1:0]         sdram_addr;
    logic                      sdram_write;
    logic                      sdram_burst;
    logic [3:0]                sdram_wstrb;
    logic [31:0]               sdram_wdata;

    // controller read-return side
    logic                      sdram_rvalid;
    logic [31:0]               sdram_rdata;
    logic [ADDR_W-1:0]         sdram_raddress;
    logic                      sdram_complete;

    logic                      protocol_error;

    modport slave (
        input  m_request, m_addr, m_write, m_burst, m_wstrb, m_wdata,
        output m_ready, m_rvalid, m_rdata, m_raddress, m_complete,
        input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        output sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        output protocol_error
    );

    modport master (
        output m_request, m_addr, m_write, m_burst, m_wstrb, m_wdata,
        input  m_ready, m_rvalid, m_rdata, m_raddress, m_complete,
        output sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        input  sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        input  protocol_error
    );

endinterface

// File: rtl/sdram_arb_owner_fifo.sv
// Owner FIFO: remembers which master issued each outstanding read, in issue
// order, so returning beats can be steered. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
// The head is read combinationally because steering happens in the same
// cycle the beat arrives; the array is tiny so it maps to registers.
module sdram_arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Store the owner id at the write slot; contents need no reset
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Advance pointers; reset flushes every outstanding entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_REQ
// masters. Grant is combinational with zero-cycle acceptance; read owners
// are queued so returning beats are steered back to the issuing master.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int OWN_DEPTH = DEF_OWN_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W
)(
    input  logic           clock,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    typedef logic [ID_W-1:0] id_t;

    id_t                rr_ptr_reg;
    id_t                rr_ptr_next;
    id_t                grant;
    id_t                fifo_head;
    logic [NUM_REQ-1:0] eligible;
    logic               any_eligible;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               protocol_error_reg;
    logic               protocol_error_next;
    logic               found;
    int                 idx;

    // Writes never need an owner slot, so only reads stall on a full FIFO.
    // Nothing is eligible while reset is held so all outputs stay quiet.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_eligible
        assign eligible[gi] = !reset && bus.m_request[gi] &&
                              (bus.m_write[gi] || !fifo_full);
    end

    assign any_eligible = |eligible;
    assign accept       = any_eligible && bus.sdram_ready;
    assign push         = accept && !bus.m_write[grant];
    assign pop          = bus.sdram_rvalid && bus.sdram_complete && !fifo_empty;

    // Pick the first eligible master scanning upward from rr_ptr with wrap
    always_comb begin
        grant = rr_ptr_reg;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible[id_t'(idx)]) begin
                grant = id_t'(idx);
                found = 1'b1;
            end
        end
    end

    // Forward the granted master's request fields; zeros when idle
    always_comb begin
        bus.sdram_request = any_eligible;
        bus.sdram_addr    = '0;
        bus.sdram_write   = 1'b0;
        bus.sdram_burst   = 1'b0;
        bus.sdram_wstrb   = '0;
        bus.sdram_wdata   = '0;
        if (any_eligible) begin
            bus.sdram_addr  = bus.m_addr[int'(grant)*ADDR_W +: ADDR_W];
            bus.sdram_write = bus.m_write[grant];
            bus.sdram_burst = bus.m_burst[grant];
            bus.sdram_wstrb = bus.m_wstrb[int'(grant)*4 +: 4];
            bus.sdram_wdata = bus.m_wdata[int'(grant)*32 +: 32];
        end
    end

    // Acknowledge only the granted master, in the cycle the controller takes it
    always_comb begin
        bus.m_ready = '0;
        if (accept) begin
            bus.m_ready[grant] = 1'b1;
        end
    end

    // Steer a returning beat to the owner at the FIFO head; orphan beats are dropped
    always_comb begin
        bus.m_rvalid = '0;
        if (bus.sdram_rvalid && !fifo_empty) begin
            bus.m_rvalid[fifo_head] = 1'b1;
        end
    end

    assign bus.m_rdata        = reset ? '0 : bus.sdram_rdata;
    assign bus.m_raddress     = reset ? '0 : bus.sdram_raddress;
    assign bus.m_complete     = reset ? 1'b0 : bus.sdram_complete;
    assign bus.protocol_error = protocol_error_reg;

    // Next round-robin pointer and sticky error flag
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            rr_ptr_next = (grant == id_t'(NUM_REQ - 1)) ? '0 : grant + id_t'(1);
        end
        protocol_error_next = protocol_error_reg | (bus.sdram_rvalid & fifo_empty);
    end

    // Register pointer and error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_reg         <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            rr_ptr_reg         <= rr_ptr_next;
            protocol_error_reg <= protocol_error_next;
        end
    end

    sdram_arb_owner_fifo #(
        .DEPTH (OWN_DEPTH),
        .W     (ID_W)
    ) u_owner_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter. Inputs change 1 time unit after
// the rising edge and outputs are sampled on the falling edge. Every
// accepted read pushes its expected beats onto a scoreboard; the bench's
// controller model returns them and each returned beat pops one entry.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int NR = DEF_NUM_REQ;
    localparam int AW = DEF_ADDR_W;

    typedef struct {
        int            owner;
        logic          complete;
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    tests_run = 0;
    int    tests_failed = 0;
    beat_t exp_beat_q[$];
    beat_t ret_q[$];

    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

    sdram_arbiter #(
        .NUM_REQ   (NR),
        .OWN_DEPTH (DEF_OWN_DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    function automatic sdram_req_t mk_req(input logic [AW-1:0] addr, input logic write,
                                          input logic burst, input logic [31:0] wdata);
        sdram_req_t r;
        r.addr  = addr;
        r.write = write;
        r.burst = burst;
        r.wstrb = write ? 4'hF : 4'h0;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic set_master(input int i, input logic req, input sdram_req_t r);
        bus.m_request[i]          = req;
        bus.m_write[i]            = r.write;
        bus.m_burst[i]            = r.burst;
        bus.m_addr[i*AW +: AW]    = r.addr;
        bus.m_wstrb[i*4 +: 4]     = r.wstrb;
        bus.m_wdata[i*32 +: 32]   = r.wdata;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < NR; i++) set_master(i, 1'b0, mk_req('0, 1'b0, 1'b0, '0));
    endtask

    task automatic idle_inputs();
        clear_masters();
        bus.sdram_ready    = 1'b0;
        bus.sdram_rvalid   = 1'b0;
        bus.sdram_rdata    = '0;
        bus.sdram_raddress = '0;
        bus.sdram_complete = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record the beats an accepted read will produce (scoreboard + controller model)
    task automatic queue_read(input int owner, input logic [AW-1:0] addr, input logic burst);
        beat_t b;
        int n;
        n = burst ? BURST_LEN : 1;
        for (int k = 0; k < n; k++) begin
            b.owner    = owner;
            b.addr     = addr + AW'(k);
            b.data     = {6'h2A, b.addr};
            b.complete = (k == n - 1);
            exp_beat_q.push_back(b);
            ret_q.push_back(b);
        end
        $display("[TB] read accepted: master %0d addr 0x%0h beats %0d", owner, addr, n);
    endtask

    // Controller model: present the next pending beat, or go idle
    task automatic drive_return();
        beat_t b;
        if (ret_q.size() == 0) begin
            bus.sdram_rvalid   = 1'b0;
            bus.sdram_complete = 1'b0;
        end else begin
            b = ret_q.pop_front();
            bus.sdram_rvalid   = 1'b1;
            bus.sdram_rdata    = b.data;
            bus.sdram_raddress = b.addr;
            bus.sdram_complete = b.complete;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.sdram_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_master(i, 1'b1, mk_req(AW'(32'h40 + i), 1'b0, 1'b0, '0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.sdram_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_request: sdram_request=%b expected 0", bus.sdram_request);
        end
        tests_run++;
        if (bus.m_ready !== 3'b000 || bus.m_rvalid !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready: m_ready=%b m_rvalid=%b expected 000/000", bus.m_ready, bus.m_rvalid);
        end
        clear_masters();
        bus.sdram_ready = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.sdram_request, bus.sdram_addr, bus.protocol_error} !== {1'b0, AW'(0), 1'b0}) begin
            tests_failed++;
            $display("FAIL after_reset: req=%b addr=%h perr=%b expected 0/0/0",
                     bus.sdram_request, bus.sdram_addr, bus.protocol_error);
        end
        tests_run++;
        if (dut.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fifo: empty=%b expected 1", dut.fifo_empty);
        end
        $display("[TB] reset checked");
        step();
    endtask

    task automatic test_round_robin();
        int            exp_grant_q[$];
        beat_t         b;
        logic [NR-1:0] exp_rv;
        logic [NR-1:0] exp_rdy;
        logic          had_beat;
        int            g;
        exp_grant_q = {0, 1, 2, 0, 1, 2};
        bus.sdram_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_master(i, 1'b1, mk_req(AW'(32'h10 + i), 1'b0, 1'b0, 32'(i)));
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc == 6) clear_masters();
            had_beat = (ret_q.size() != 0);
            drive_return();
            @(negedge clk);
            exp_rdy = '0;
            g = -1;
            if (cyc < 6) begin
                g = exp_grant_q.pop_front();
                exp_rdy[g] = 1'b1;
            end
            tests_run++;
            if (bus.m_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rr_grant cyc%0d: m_ready=%b expected %b", cyc, bus.m_ready, exp_rdy);
            end
            if (had_beat) begin
                b = exp_beat_q.pop_front();
                exp_rv = '0;
                exp_rv[b.owner] = 1'b1;
                tests_run++;
                if ({bus.m_rvalid, bus.m_complete, bus.m_rdata} !== {exp_rv, b.complete, b.data}) begin
                    tests_failed++;
                    $display("FAIL rr_return cyc%0d: rvalid=%b cpl=%b data=%h expected %b/%b/%h",
                             cyc, bus.m_rvalid, bus.m_complete, bus.m_rdata, exp_rv, b.complete, b.data);
                end
            end
            if (g >= 0) begin
                tests_run++;
                if (bus.sdram_addr !== AW'(32'h10 + g)) begin
                    tests_failed++;
                    $display("FAIL rr_payload cyc%0d: addr=%h expected %h", cyc, bus.sdram_addr, AW'(32'h10 + g));
                end
                queue_read(g, AW'(32'h10 + g), 1'b0);
            end
            step();
        end
        drive_return();
        @(negedge clk);
        tests_run++;
        if (dut.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_fifo_empty: empty=%b expected 1", dut.fifo_empty);
        end
        step();
    endtask

    task automatic test_burst_return();
        beat_t         b;
        logic [NR-1:0] exp_rv;
        bus.sdram_ready = 1'b1;
        set_master(1, 1'b1, mk_req(AW'(32'h100), 1'b0, 1'b1, 32'hB1));
        @(negedge clk);
        tests_run++;
        if ({bus.m_ready, bus.sdram_burst, bus.sdram_addr} !== {3'b010, 1'b1, AW'(32'h100)}) begin
            tests_failed++;
            $display("FAIL burst_issue: ready=%b burst=%b addr=%h expected 010/1/100",
                     bus.m_ready, bus.sdram_burst, bus.sdram_addr);
        end
        queue_read(1, AW'(32'h100), 1'b1);
        step();
        clear_masters();
        set_master(0, 1'b1, mk_req(AW'(32'h200), 1'b0, 1'b0, 32'hA0));
        @(negedge clk);
        tests_run++;
        if ({bus.m_ready, bus.sdram_burst, bus.sdram_addr} !== {3'b001, 1'b0, AW'(32'h200)}) begin
            tests_failed++;
            $display("FAIL single_issue: ready=%b burst=%b addr=%h expected 001/0/200",
                     bus.m_ready, bus.sdram_burst, bus.sdram_addr);
        end
        queue_read(0, AW'(32'h200), 1'b0);
        step();
        clear_masters();
        while (ret_q.size() != 0) begin
            drive_return();
            @(negedge clk);
            b = exp_beat_q.pop_front();
            exp_rv = '0;
            exp_rv[b.owner] = 1'b1;
            tests_run++;
            if ({bus.m_rvalid, bus.m_complete, bus.m_rdata, bus.m_raddress} !==
                {exp_rv, b.complete, b.data, b.addr}) begin
                tests_failed++;
                $display("FAIL burst_beat addr %h: rvalid=%b cpl=%b data=%h raddr=%h expected %b/%b/%h/%h",
                         b.addr, bus.m_rvalid, bus.m_complete, bus.m_rdata, bus.m_raddress,
                         exp_rv, b.complete, b.data, b.addr);
            end
            step();
        end
        drive_return();
        @(negedge clk);
        tests_run++;
        if (dut.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_fifo_empty: empty=%b expected 1", dut.fifo_empty);
        end
        $display("[TB] burst + single returned");
        step();
    endtask

    task automatic test_fifo_full();
        beat_t         b;
        logic [NR-1:0] exp_rv;
        bus.sdram_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_master(0, 1'b1, mk_req(AW'(32'h300 + k), 1'b0, 1'b0, 32'(k)));
            @(negedge clk);
            tests_run++;
            if (bus.m_ready !== 3'b001) begin
                tests_failed++;
                $display("FAIL fill_read %0d: m_ready=%b expected 001", k, bus.m_ready);
            end
            queue_read(0, AW'(32'h300 + k), 1'b0);
            step();
        end
        // FIFO full: master 0 read waits, master 2 write still goes
        set_master(0, 1'b1, mk_req(AW'(32'h304), 1'b0, 1'b0, 32'h4));
        set_master(2, 1'b1, mk_req(AW'(32'h3F0), 1'b1, 1'b0, 32'hDEAD_BEEF));
        @(negedge clk);
        tests_run++;
        if ({bus.m_ready, bus.sdram_write, bus.sdram_addr, bus.sdram_wdata} !==
            {3'b100, 1'b1, AW'(32'h3F0), 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL full_write: ready=%b write=%b addr=%h wdata=%h expected 100/1/3f0/deadbeef",
                     bus.m_ready, bus.sdram_write, bus.sdram_addr, bus.sdram_wdata);
        end
        $display("[TB] write accepted: master 2 addr 0x3f0");
        step();
        set_master(2, 1'b0, mk_req('0, 1'b0, 1'b0, '0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.m_ready, bus.sdram_request} !== {3'b000, 1'b0}) begin
                tests_failed++;
                $display("FAIL full_stall %0d: ready=%b req=%b expected 000/0", k, bus.m_ready, bus.sdram_request);
            end
            step();
        end
        // First completion pops, but the read only goes on the next cycle
        drive_return();
        @(negedge clk);
        b = exp_beat_q.pop_front();
        exp_rv = '0;
        exp_rv[b.owner] = 1'b1;
        tests_run++;
        if ({bus.m_ready, bus.m_rvalid, bus.m_complete} !== {3'b000, exp_rv, 1'b1}) begin
            tests_failed++;
            $display("FAIL full_pop_no_bypass: ready=%b rvalid=%b cpl=%b expected 000/%b/1",
                     bus.m_ready, bus.m_rvalid, bus.m_complete, exp_rv);
        end
        step();
        bus.sdram_rvalid   = 1'b0;
        bus.sdram_complete = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL full_resume: m_ready=%b expected 001", bus.m_ready);
        end
        queue_read(0, AW'(32'h304), 1'b0);
        step();
        clear_masters();
        while (ret_q.size() != 0) begin
            drive_return();
            @(negedge clk);
            b = exp_beat_q.pop_front();
            exp_rv = '0;
            exp_rv[b.owner] = 1'b1;
            tests_run++;
            if ({bus.m_rvalid, bus.m_raddress} !== {exp_rv, b.addr}) begin
                tests_failed++;
                $display("FAIL full_drain addr %h: rvalid=%b raddr=%h expected %b/%h",
                         b.addr, bus.m_rvalid, bus.m_raddress, exp_rv, b.addr);
            end
            step();
        end
        drive_return();
    endtask

    task automatic test_ready_stall();
        beat_t         b;
        logic [NR-1:0] exp_rv;
        bus.sdram_ready = 1'b0;
        set_master(0, 1'b1, mk_req(AW'(32'h3A5), 1'b0, 1'b0, 32'h0000_CAFE));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.sdram_request, bus.sdram_addr, bus.sdram_wdata, bus.m_ready} !==
                {1'b1, AW'(32'h3A5), 32'h0000_CAFE, 3'b000}) begin
                tests_failed++;
                $display("FAIL stall %0d: req=%b addr=%h tag=%h ready=%b expected 1/3a5/cafe/000",
                         k, bus.sdram_request, bus.sdram_addr, bus.sdram_wdata, bus.m_ready);
            end
            step();
        end
        bus.sdram_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL stall_accept: m_ready=%b expected 001", bus.m_ready);
        end
        queue_read(0, AW'(32'h3A5), 1'b0);
        step();
        // Pointer moved past master 0: master 1 wins over master 2, then master 2
        clear_masters();
        set_master(1, 1'b1, mk_req(AW'(32'h111), 1'b1, 1'b0, 32'h1));
        set_master(2, 1'b1, mk_req(AW'(32'h222), 1'b1, 1'b0, 32'h2));
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL stall_rr_next: m_ready=%b expected 010", bus.m_ready);
        end
        step();
        set_master(1, 1'b0, mk_req('0, 1'b0, 1'b0, '0));
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b100) begin
            tests_failed++;
            $display("FAIL stall_rr_next2: m_ready=%b expected 100", bus.m_ready);
        end
        step();
        clear_masters();
        while (ret_q.size() != 0) begin
            drive_return();
            @(negedge clk);
            b = exp_beat_q.pop_front();
            exp_rv = '0;
            exp_rv[b.owner] = 1'b1;
            tests_run++;
            if ({bus.m_rvalid, bus.m_rdata} !== {exp_rv, b.data}) begin
                tests_failed++;
                $display("FAIL stall_return: rvalid=%b data=%h expected %b/%h",
                         bus.m_rvalid, bus.m_rdata, exp_rv, b.data);
            end
            step();
        end
        drive_return();
    endtask

    task automatic test_protocol_error();
        bus.sdram_rvalid   = 1'b1;
        bus.sdram_complete = 1'b1;
        bus.sdram_rdata    = 32'h1234_5678;
        @(negedge clk);
        tests_run++;
        if ({bus.m_rvalid, bus.protocol_error} !== {3'b000, 1'b0}) begin
            tests_failed++;
            $display("FAIL orphan_beat: rvalid=%b perr=%b expected 000/0", bus.m_rvalid, bus.protocol_error);
        end
        step();
        bus.sdram_rvalid   = 1'b0;
        bus.sdram_complete = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.protocol_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL perr_set: protocol_error=%b expected 1", bus.protocol_error);
        end
        repeat (3) step();
        @(negedge clk);
        tests_run++;
        if (bus.protocol_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL perr_sticky: protocol_error=%b expected 1", bus.protocol_error);
        end
        $display("[TB] orphan beat flagged");
        step();
    endtask

    task automatic test_reset_midburst();
        beat_t         b;
        logic [NR-1:0] exp_rv;
        bus.sdram_ready = 1'b1;
        set_master(1, 1'b1, mk_req(AW'(32'h500), 1'b0, 1'b1, '0));
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL mid_issue1: m_ready=%b expected 010", bus.m_ready);
        end
        queue_read(1, AW'(32'h500), 1'b1);
        step();
        clear_masters();
        set_master(2, 1'b1, mk_req(AW'(32'h600), 1'b0, 1'b1, '0));
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b100) begin
            tests_failed++;
            $display("FAIL mid_issue2: m_ready=%b expected 100", bus.m_ready);
        end
        queue_read(2, AW'(32'h600), 1'b1);
        step();
        clear_masters();
        for (int k = 0; k < 3; k++) begin
            drive_return();
            @(negedge clk);
            b = exp_beat_q.pop_front();
            exp_rv = '0;
            exp_rv[b.owner] = 1'b1;
            tests_run++;
            if ({bus.m_rvalid, bus.m_complete} !== {exp_rv, 1'b0}) begin
                tests_failed++;
                $display("FAIL mid_beat %0d: rvalid=%b cpl=%b expected %b/0", k, bus.m_rvalid, bus.m_complete, exp_rv);
            end
            step();
        end
        // Beat in flight and master 0 asking for a write when reset lands between edges
        drive_return();
        set_master(0, 1'b1, mk_req(AW'(32'h700), 1'b1, 1'b0, 32'h77));
        #2;
        rst = 1'b1;
        bus.sdram_rvalid   = 1'b0;
        bus.sdram_complete = 1'b0;
        #1;
        tests_run++;
        if ({bus.sdram_request, bus.m_ready, bus.m_rvalid} !== {1'b0, 3'b000, 3'b000}) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: req=%b ready=%b rvalid=%b expected 0/000/000",
                     bus.sdram_request, bus.m_ready, bus.m_rvalid);
        end
        tests_run++;
        if ({bus.protocol_error, dut.fifo_empty} !== 2'b01) begin
            tests_failed++;
            $display("FAIL async_reset_state: perr=%b fifo_empty=%b expected 0/1",
                     bus.protocol_error, dut.fifo_empty);
        end
        ret_q.delete();
        exp_beat_q.delete();
        step();
        step();
        for (int i = 0; i < NR; i++) set_master(i, 1'b1, mk_req(AW'(32'h800 + i), 1'b1, 1'b0, 32'(i)));
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL post_reset_first: m_ready=%b expected 001", bus.m_ready);
        end
        step();
        set_master(0, 1'b0, mk_req('0, 1'b0, 1'b0, '0));
        @(negedge clk);
        tests_run++;
        if (bus.m_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL post_reset_second: m_ready=%b expected 010", bus.m_ready);
        end
        $display("[TB] reset mid-burst recovered");
        step();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_burst_return();
        test_fifo_full();
        test_ready_stall();
        test_protocol_error();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
